// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding, Q.12 constants and saturating add for the LIF neuron units
package snn_pkg;

    typedef enum logic [2:0] {IDLE, DECAY, FETCH, ACC, FIRE, WAIT3} state_t;

    localparam int D_Q12       = 614;
    localparam int PRES_Q12    = 0;
    localparam int PMIN_Q12    = -2048000;
    localparam int TH_INIT_Q12 = 15018;

    // a+b clamped to the signed w-bit range; callers sign-extend into 64 bits and truncate back
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
        logic signed [63:0] s, hi, lo;
        s  = a + b;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return s > hi ? hi : s < lo ? lo : s;
    endfunction

endpackage

// File: rtl/ref_timer.sv
// ref_timer: refractory counter with one-shot dec pulse
//   clk, rst_n        clock, async active-low reset
//   tu_incre          time-unit tick, counts up to REF+1 and holds there
//   spike             qualified spike, restarts the count at 0 (beats tu_incre)
//   clr               per-image clear, forces the count to REF+1
//   refr              count has not yet reached REF+1
//   dec               one-cycle pulse the cycle after the count first equals DEC_AT
module ref_timer #(
    parameter int REF    = 30,
    parameter int DEC_AT = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tu_incre,
    input  logic spike,
    input  logic clr,
    output logic refr,
    output logic dec
);

    localparam int CW = $clog2(REF + 2);
    localparam logic [CW-1:0] TOP = CW'(REF + 1);
    localparam logic [CW-1:0] AT  = CW'(DEC_AT);

    logic [CW-1:0] cnt;
    logic at_q;

    assign refr = cnt != TOP;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt  <= TOP;
            at_q <= 1'b0;
            dec  <= 1'b0;
        end else begin
            cnt  <= clr ? TOP : spike ? '0 : tu_incre && cnt != TOP ? cnt + CW'(1) : cnt;
            at_q <= !clr && cnt == AT;
            // the count can sit at DEC_AT for many cycles between ticks; pulse only on arrival
            dec  <= !clr && cnt == AT && !at_q;
        end

endmodule

// File: rtl/pot_adder_gen.sv
// pot_adder_gen: leaky integrate-and-fire membrane potential for one neuron
//   clk, rst_n                          clock, async active-low reset
//   clr                                 per-image clear (threshold kept)
//   tu_incre                            time-unit tick for the refractory timer
//   start_pp1/2/3                       decay / integrate-fire / integrate-wait-decide
//   pp3_go, won                         winner-take-all decision and its result
//   spike_in, data_r, addr_r            presynaptic spikes, weight RAM (1-cycle read latency)
//   thr_load, thr_in                    threshold write
//   potential, spike_pp                 membrane potential, fire flag
//   valid_pp1/2/3m/3                    one-cycle completion pulses
//   busy, start_err, refr, dec          status
module pot_adder_gen
    import snn_pkg::*;
#(
    parameter int NIN     = 784,
    parameter int W       = 32,
    parameter int AW      = 10,
    parameter int D       = D_Q12,
    parameter int PRES    = PRES_Q12,
    parameter int PMIN    = PMIN_Q12,
    parameter int TH_INIT = TH_INIT_Q12,
    parameter int REF     = 30,
    parameter int DEC_AT  = 21
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           tu_incre,
    input  logic           start_pp1,
    input  logic           start_pp2,
    input  logic           start_pp3,
    input  logic           pp3_go,
    input  logic           won,
    input  logic [NIN-1:0] spike_in,
    input  logic [W-1:0]   data_r,
    input  logic           thr_load,
    input  logic [W-1:0]   thr_in,
    output logic [AW-1:0]  addr_r,
    output logic [W-1:0]   potential,
    output logic           spike_pp,
    output logic           valid_pp1,
    output logic           valid_pp2,
    output logic           valid_pp3m,
    output logic           valid_pp3,
    output logic           busy,
    output logic           start_err,
    output logic           refr,
    output logic           dec
);

    localparam logic signed [W-1:0] P_D    = W'(D);
    localparam logic signed [W-1:0] P_RES  = W'(PRES);
    localparam logic signed [W-1:0] P_MIN  = W'(PMIN);
    localparam logic signed [W-1:0] P_TH   = W'(TH_INIT);
    localparam logic [AW-1:0]       LAST   = AW'(NIN - 1);

    function automatic logic signed [W-1:0] sadd(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        return W'(sat_add(64'(a), 64'(b), W));
    endfunction

    state_t state, state_nx;
    logic signed [W-1:0] pot, pot_nx, thr, thr_nx, half, fire_pot, lose_pot;
    logic [AW-1:0] addr_nx, pidx, pidx_nx;
    logic pend, pend_nx, m3, m3_nx, skip, skip_nx, fire_spk;
    logic spk_nx, v1_nx, v2_nx, v3m_nx, v3_nx, serr_nx;

    assign potential = pot;
    assign busy      = state != IDLE;

    assign half     = thr >>> 1;
    assign fire_spk = pot >= P_MIN && pot > thr;
    assign fire_pot = pot < P_MIN || pot > thr ? P_RES : pot > P_RES ? sadd(pot, -P_D) : pot;
    assign lose_pot = pot > sadd(half, P_RES) ? sadd(pot, -half) : P_RES;

    ref_timer #(.REF(REF), .DEC_AT(DEC_AT)) u_ref (
        .clk      (clk),
        .rst_n    (rst_n),
        .tu_incre (tu_incre),
        .spike    ((valid_pp2 | valid_pp3) & spike_pp),
        .clr      (clr),
        .refr     (refr),
        .dec      (dec)
    );

    // pend/pidx trail addr_r by one edge so each add lines up with the RAM read latency
    always_comb begin
        state_nx = state;
        pot_nx   = pend && spike_in[pidx] ? sadd(pot, $signed(data_r)) : pot;
        addr_nx  = addr_r;
        spk_nx   = spike_pp;
        v1_nx    = 1'b0;
        v2_nx    = 1'b0;
        v3m_nx   = 1'b0;
        v3_nx    = 1'b0;
        serr_nx  = !clr && state != IDLE && (start_pp1 || start_pp2 || start_pp3);
        pend_nx  = state == FETCH;
        pidx_nx  = addr_r;
        m3_nx    = m3;
        skip_nx  = skip;
        thr_nx   = thr_load ? $signed(thr_in) : thr;
        if (clr) begin
            state_nx = IDLE;
            pot_nx   = P_RES;
            addr_nx  = '0;
            pend_nx  = 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (start_pp1)
                        state_nx = DECAY;
                    else if (start_pp2 || start_pp3) begin
                        m3_nx   = !start_pp2;
                        skip_nx = refr;
                        if (refr) begin
                            spk_nx   = start_pp2 ? 1'b0 : spike_pp;
                            v2_nx    = start_pp2;
                            v3m_nx   = !start_pp2;
                            state_nx = start_pp2 ? IDLE : WAIT3;
                        end else
                            state_nx = FETCH;
                    end
                DECAY: begin
                    pot_nx   = refr || pot <= P_RES ? pot : sadd(pot, -P_D);
                    spk_nx   = 1'b0;
                    v1_nx    = 1'b1;
                    state_nx = IDLE;
                end
                FETCH: begin
                    addr_nx  = addr_r == LAST ? '0 : addr_r + AW'(1);
                    state_nx = addr_r == LAST ? ACC : FETCH;
                end
                ACC:
                    state_nx = FIRE;
                FIRE:
                    if (m3) begin
                        v3m_nx   = 1'b1;
                        state_nx = WAIT3;
                    end else begin
                        pot_nx   = fire_pot;
                        spk_nx   = fire_spk;
                        v2_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                WAIT3:
                    if (pp3_go) begin
                        pot_nx   = skip ? pot : won ? fire_pot : lose_pot;
                        spk_nx   = !skip && won && fire_spk;
                        v3_nx    = 1'b1;
                        state_nx = IDLE;
                    end
                default:
                    state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            pot        <= P_RES;
            thr        <= P_TH;
            addr_r     <= '0;
            spike_pp   <= 1'b0;
            valid_pp1  <= 1'b0;
            valid_pp2  <= 1'b0;
            valid_pp3m <= 1'b0;
            valid_pp3  <= 1'b0;
            start_err  <= 1'b0;
            pend       <= 1'b0;
            pidx       <= '0;
            m3         <= 1'b0;
            skip       <= 1'b0;
        end else begin
            state      <= state_nx;
            pot        <= pot_nx;
            thr        <= thr_nx;
            addr_r     <= addr_nx;
            spike_pp   <= spk_nx;
            valid_pp1  <= v1_nx;
            valid_pp2  <= v2_nx;
            valid_pp3m <= v3m_nx;
            valid_pp3  <= v3_nx;
            start_err  <= serr_nx;
            pend       <= pend_nx;
            pidx       <= pidx_nx;
            m3         <= m3_nx;
            skip       <= skip_nx;
        end

endmodule
